cte_scheduler: RTL

Front-end scheduler for the CTE colour-transform engine: arbitrates whole pixel groups between a YUV→RGB requester and an RGB→YUV requester, drives CTE `op_mode`/`in_en`/data while honouring `busy`, collects `out_valid` results, and returns one packed response per group. It sits between the stream buffers and the single CTE instance, and it is the only block that drives CTE inputs.

---
 rtl/cte_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cte_scheduler.sv
// Front-end scheduler for the CTE colour-transform engine: arbitrates whole pixel groups between
// the YUV->RGB and RGB->YUV requesters and packs CTE results. Optional watchdog: CTE_SCHED_WDOG_EN.
module cte_scheduler #(
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        y_req_valid,
  input  logic [31:0] y_req_data,
  output logic        y_req_ready,
  input  logic        r_req_valid,
  input  logic [47:0] r_req_data,
  output logic        r_req_ready,
  output logic        y_rsp_valid,
  output logic [47:0] y_rsp_data,
  input  logic        y_rsp_ready,
  output logic        r_rsp_valid,
  output logic [31:0] r_rsp_data,
  input  logic        r_rsp_ready,
  output logic        rsp_err,
  output logic        cte_op_mode,
  output logic        cte_in_en,
  output logic [7:0]  cte_yuv_in,
  output logic [23:0] cte_rgb_in,
  input  logic        cte_busy,
  input  logic        cte_out_valid,
  input  logic [23:0] cte_rgb_out,
  input  logic [7:0]  cte_yuv_out
);

  // state | meaning
  // IDLE  | arbitrate, latch granted group
  // FEED  | issue 4 beats to the CTE, stall on busy
  // DRAIN | wait for the remaining CTE results
  // RESP  | hold response until the consumer accepts
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESP} state_t;

  if (CNT_W < 2) begin : g_cnt_w_chk
    $error("cte_scheduler: CNT_W must be at least 2");
  end

  state_t      state_q, state_d;
  logic [47:0] grp_q, grp_d;
  logic [47:0] res_q, res_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  rcnt_q, rcnt_d;
  logic        mode_q, mode_d;
  logic        prio_r_q, prio_r_d;
  logic        gnt_y, gnt_r, in_en;
  logic [2:0]  exp_cnt;
  logic [7:0]  yuv_byte;
`ifdef CTE_SCHED_WDOG_EN
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grp_q    <= '0;
      res_q    <= '0;
      beat_q   <= '0;
      rcnt_q   <= '0;
      mode_q   <= 1'b0;
      prio_r_q <= 1'b0;
`ifdef CTE_SCHED_WDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      res_q    <= res_d;
      beat_q   <= beat_d;
      rcnt_q   <= rcnt_d;
      mode_q   <= mode_d;
      prio_r_q <= prio_r_d;
`ifdef CTE_SCHED_WDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    res_d    = res_q;
    beat_d   = beat_q;
    rcnt_d   = rcnt_q;
    mode_d   = mode_q;
    prio_r_d = prio_r_q;
    gnt_y    = 1'b0;
    gnt_r    = 1'b0;
    in_en    = 1'b0;
    exp_cnt  = mode_q ? 3'd4 : 3'd2;
`ifdef CTE_SCHED_WDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // prio_r_q set means Y was granted last, so R wins a tie
        gnt_y = y_req_valid && (!r_req_valid || !prio_r_q);
        gnt_r = r_req_valid && (!y_req_valid || prio_r_q);
        if (gnt_y || gnt_r) begin
          grp_d    = gnt_y ? {16'h0000, y_req_data} : r_req_data;
          mode_d   = gnt_r;
          prio_r_d = gnt_y;
          beat_d   = 2'd0;
          rcnt_d   = 3'd0;
          res_d    = '0;
`ifdef CTE_SCHED_WDOG_EN
          err_d    = 1'b0;
`endif
          state_d  = FEED;
        end
      end
      FEED: begin
        if (!cte_busy) begin
          in_en  = 1'b1;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DRAIN;
        end
      end
      DRAIN: ;
      RESP: begin
        if (mode_q ? r_rsp_ready : y_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == FEED || state_q == DRAIN) && cte_out_valid && rcnt_q < exp_cnt) begin
      if (mode_q) begin
        unique case (rcnt_q[1:0])
          2'd0: res_d[31:24] = cte_yuv_out;
          2'd1: res_d[23:16] = cte_yuv_out;
          2'd2: res_d[15:8]  = cte_yuv_out;
          default: res_d[7:0] = cte_yuv_out;
        endcase
      end else if (rcnt_q[0]) begin
        res_d[23:0] = cte_rgb_out;
      end else begin
        res_d[47:24] = cte_rgb_out;
      end
      rcnt_d = rcnt_q + 3'd1;
    end

    if (state_q == DRAIN && rcnt_d == exp_cnt) state_d = RESP;

`ifdef CTE_SCHED_WDOG_EN
    // a normal completion in the same cycle as expiry wins over the abort
    if (state_q == FEED) begin
      wd_d = '0;
    end else if (state_q == DRAIN) begin
      wd_d = wd_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state_d == DRAIN && &wd_d) begin
        state_d = RESP;
        err_d   = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    unique case (beat_q)
      2'd0: yuv_byte = grp_q[31:24];
      2'd1: yuv_byte = grp_q[23:16];
      2'd2: yuv_byte = grp_q[15:8];
      default: yuv_byte = grp_q[7:0];
    endcase
  end

  // gated by reset so the grant pulse cannot leak out while reset is held
  assign y_req_ready = reset & gnt_y;
  assign r_req_ready = reset & gnt_r;
  assign cte_in_en   = in_en;
  assign cte_op_mode = mode_q;
  assign cte_yuv_in  = (state_q == FEED && !mode_q) ? yuv_byte : 8'h00;
  assign cte_rgb_in  = (state_q == FEED && mode_q) ?
                       (beat_q[1] ? grp_q[23:0] : grp_q[47:24]) : 24'h000000;
  assign y_rsp_valid = (state_q == RESP) && !mode_q;
  assign r_rsp_valid = (state_q == RESP) && mode_q;
  assign y_rsp_data  = y_rsp_valid ? res_q : 48'h0;
  assign r_rsp_data  = r_rsp_valid ? res_q[31:0] : 32'h0;
`ifdef CTE_SCHED_WDOG_EN
  assign rsp_err     = (state_q == RESP) & err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule
